// File: rtl/exwb_stage_pkg.sv
// rtl/exwb_stage_pkg.sv - shared flag bit positions and skid depth for the EX/WB stage
package exwb_stage_pkg;

    // Bit positions of the architectural flags inside the 4-bit flag register
    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_S = 3;

    // Number of entries in the writeback skid buffer
    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/exwb_skid.sv
// rtl/exwb_skid.sv - 2-entry FIFO skid buffer with writeback handshake and registered forwarding port
module exwb_skid
    import exwb_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          flush,
    input  logic [DW-1:0] in_data,
    input  logic [RW-1:0] in_rdest,
    input  logic          in_wen,
    output logic          ready,
    output logic          wb_valid,
    input  logic          wb_ready,
    output logic [DW-1:0] wb_data,
    output logic [RW-1:0] wb_rdest,
    output logic          wb_wen,
    output logic          fwd_hit_valid,
    output logic [RW-1:0] fwd_rdest,
    output logic [DW-1:0] fwd_data
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0] state, state_n;
    logic       wr_ptr, wr_ptr_n;
    logic       rd_ptr, rd_ptr_n;
    logic       pop;

    logic [SKID_DEPTH-1:0][DW-1:0] mem_data, mem_data_n;
    logic [SKID_DEPTH-1:0][RW-1:0] mem_rdest, mem_rdest_n;
    logic [SKID_DEPTH-1:0]         mem_wen, mem_wen_n;

    logic          young, old;
    logic          hit_young, hit_old;
    logic          fwd_hit_n;
    logic [RW-1:0] fwd_rdest_n;
    logic [DW-1:0] fwd_data_n;

    // Ready comes only from registered state, so a same-cycle pop never raises it
    assign ready    = (state != FULL);
    assign wb_valid = (state != EMPTY);
    assign pop      = wb_valid & wb_ready;
    assign wb_data  = mem_data[rd_ptr];
    assign wb_rdest = mem_rdest[rd_ptr];
    assign wb_wen   = mem_wen[rd_ptr];

    // Occupancy transitions; flush wins over everything else
    always_comb begin
        state_n = state;
        case (state)
            EMPTY:   if (push) state_n = ONE;
            ONE:     if (push && !pop) state_n = FULL;
                     else if (!push && pop) state_n = EMPTY;
            FULL:    if (pop) state_n = ONE;
            default: state_n = EMPTY;
        endcase
        if (flush) state_n = EMPTY;
        wr_ptr_n = flush ? 1'b0 : (wr_ptr ^ push);
        rd_ptr_n = flush ? 1'b0 : (rd_ptr ^ pop);
    end

    // Slot contents after this edge; also used to precompute the forwarding view
    always_comb begin
        mem_data_n  = mem_data;
        mem_rdest_n = mem_rdest;
        mem_wen_n   = mem_wen;
        if (push) begin
            mem_data_n[wr_ptr]  = in_data;
            mem_rdest_n[wr_ptr] = in_rdest;
            mem_wen_n[wr_ptr]   = in_wen;
        end
    end

    // Youngest writing entry of the next buffer contents, so fwd_* can be plain flops
    always_comb begin
        young       = ~wr_ptr_n;
        old         = wr_ptr_n;
        hit_young   = (state_n != EMPTY) && mem_wen_n[young];
        hit_old     = (state_n == FULL) && mem_wen_n[old];
        fwd_hit_n   = hit_young | hit_old;
        fwd_rdest_n = '0;
        fwd_data_n  = '0;
        if (hit_young) begin
            fwd_rdest_n = mem_rdest_n[young];
            fwd_data_n  = mem_data_n[young];
        end else if (hit_old) begin
            fwd_rdest_n = mem_rdest_n[old];
            fwd_data_n  = mem_data_n[old];
        end
    end

    // State, pointers, storage and forwarding registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= EMPTY;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            mem_data      <= '0;
            mem_rdest     <= '0;
            mem_wen       <= '0;
            fwd_hit_valid <= 1'b0;
            fwd_rdest     <= '0;
            fwd_data      <= '0;
        end else begin
            state         <= state_n;
            wr_ptr        <= wr_ptr_n;
            rd_ptr        <= rd_ptr_n;
            mem_data      <= mem_data_n;
            mem_rdest     <= mem_rdest_n;
            mem_wen       <= mem_wen_n;
            fwd_hit_valid <= fwd_hit_n;
            fwd_rdest     <= fwd_rdest_n;
            fwd_data      <= fwd_data_n;
        end
    end

endmodule

// File: rtl/exwb_stage.sv
// rtl/exwb_stage.sv - EX/WB stage: flag register, result formatting, branch pulse, skid buffer (optional FLAG_SHADOW_EN)
module exwb_stage
    import exwb_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
`ifdef FLAG_SHADOW_EN
    input  logic          flag_save,
    input  logic          flag_restore,
`endif
    input  logic          ex_valid,
    output logic          ex_ready,
    input  logic [DW-1:0] ex_dout,
    input  logic          ex_cout,
    input  logic          ex_vout,
    input  logic          ex_djtaken,
    input  logic          ex_dj,
    input  logic [RW-1:0] ex_rdest,
    input  logic          ex_wen,
    input  logic          ex_setf,
    input  logic          ex_movt,
    input  logic          flush,
    output logic          flag_c,
    output logic          flag_v,
    output logic          flag_z,
    output logic          flag_s,
    output logic          br_taken,
    output logic          wb_valid,
    input  logic          wb_ready,
    output logic [DW-1:0] wb_data,
    output logic [RW-1:0] wb_rdest,
    output logic          wb_wen,
    output logic          fwd_hit_valid,
    output logic [RW-1:0] fwd_rdest,
    output logic [DW-1:0] fwd_data
);

    logic          acc;
    logic [DW-1:0] data_fmt;
    logic [3:0]    flags;
    logic [3:0]    flags_new;

    assign acc      = ex_valid & ex_ready;
    assign data_fmt = ex_movt ? {ex_dout[15:0], {(DW-16){1'b0}}} : ex_dout;

    assign flag_c = flags[FLAG_C];
    assign flag_v = flags[FLAG_V];
    assign flag_z = flags[FLAG_Z];
    assign flag_s = flags[FLAG_S];

    // Flag values an ex_setf commit would produce from the formatted result
    always_comb begin
        flags_new         = '0;
        flags_new[FLAG_C] = ex_cout;
        flags_new[FLAG_V] = ex_vout;
        flags_new[FLAG_Z] = (data_fmt == '0);
        flags_new[FLAG_S] = data_fmt[DW-1];
    end

`ifdef FLAG_SHADOW_EN
    logic [3:0] shadow;

    // Flag register with shadow; restore beats a same-cycle commit, save captures pre-edge flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags  <= '0;
            shadow <= '0;
        end else begin
            if (flag_restore) flags <= shadow;
            else if (acc && ex_setf) flags <= flags_new;
            if (flag_save) shadow <= flags;
        end
    end
`else
    // Flag register; committed by an accepted setf instruction even if flushed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) flags <= '0;
        else if (acc && ex_setf) flags <= flags_new;
    end
`endif

    // One-cycle taken-branch pulse; flush does not suppress it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) br_taken <= 1'b0;
        else     br_taken <= acc & ex_dj & ex_djtaken;
    end

    exwb_skid #(.DW(DW), .RW(RW)) u_skid (
        .clk           (clk),
        .rst           (rst),
        .push          (acc & ~flush),
        .flush         (flush),
        .in_data       (data_fmt),
        .in_rdest      (ex_rdest),
        .in_wen        (ex_wen),
        .ready         (ex_ready),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_data       (wb_data),
        .wb_rdest      (wb_rdest),
        .wb_wen        (wb_wen),
        .fwd_hit_valid (fwd_hit_valid),
        .fwd_rdest     (fwd_rdest),
        .fwd_data      (fwd_data)
    );

endmodule

// File: tb/tb_exwb_stage.sv
// tb/tb_exwb_stage.sv - randomized self-checking bench for exwb_stage against a queue-based model
module tb_exwb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_dout;
    logic        ex_cout, ex_vout, ex_djtaken, ex_dj;
    logic [3:0]  ex_rdest;
    logic        ex_wen, ex_setf, ex_movt, flush;
    logic        flag_c, flag_v, flag_z, flag_s, br_taken;
    logic        wb_valid, wb_ready;
    logic [31:0] wb_data;
    logic [3:0]  wb_rdest;
    logic        wb_wen;
    logic        fwd_hit_valid;
    logic [3:0]  fwd_rdest;
    logic [31:0] fwd_data;
    logic        flag_save, flag_restore;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  r;
        logic        w;
    } ent_t;

    ent_t       q[$];
    logic [3:0] m_f;
    logic [3:0] m_sh;
    logic       m_br;

    exwb_stage #(.DW(32), .RW(4)) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef FLAG_SHADOW_EN
        .flag_save     (flag_save),
        .flag_restore  (flag_restore),
`endif
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_dout       (ex_dout),
        .ex_cout       (ex_cout),
        .ex_vout       (ex_vout),
        .ex_djtaken    (ex_djtaken),
        .ex_dj         (ex_dj),
        .ex_rdest      (ex_rdest),
        .ex_wen        (ex_wen),
        .ex_setf       (ex_setf),
        .ex_movt       (ex_movt),
        .flush         (flush),
        .flag_c        (flag_c),
        .flag_v        (flag_v),
        .flag_z        (flag_z),
        .flag_s        (flag_s),
        .br_taken      (br_taken),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_data       (wb_data),
        .wb_rdest      (wb_rdest),
        .wb_wen        (wb_wen),
        .fwd_hit_valid (fwd_hit_valid),
        .fwd_rdest     (fwd_rdest),
        .fwd_data      (fwd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_idle();
        ex_valid = 0; ex_dout = 0; ex_cout = 0; ex_vout = 0; ex_djtaken = 0; ex_dj = 0;
        ex_rdest = 0; ex_wen = 0; ex_setf = 0; ex_movt = 0; flush = 0;
        flag_save = 0; flag_restore = 0;
    endtask

    task automatic model_reset();
        q.delete();
        m_f = 0; m_sh = 0; m_br = 0;
    endtask

    // Compare every observable output against the model's view of the buffer and flags
    task automatic compare_all();
        bit         hit;
        ent_t       y;
        chk("wb_valid", wb_valid, q.size() > 0);
        chk("ex_ready", ex_ready, q.size() < 2);
        if (q.size() > 0) begin
            chk("wb_data", wb_data, q[0].d);
            chk("wb_rdest", wb_rdest, q[0].r);
            chk("wb_wen", wb_wen, q[0].w);
        end
        hit = 0;
        y = '{d: 0, r: 0, w: 0};
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].w && !hit) begin
                hit = 1;
                y = q[i];
            end
        end
        chk("fwd_hit", fwd_hit_valid, hit);
        chk("fwd_rdest", fwd_rdest, hit ? y.r : 4'd0);
        chk("fwd_data", fwd_data, hit ? y.d : 32'd0);
        chk("flags", {flag_s, flag_z, flag_v, flag_c}, m_f);
        chk("br_taken", br_taken, m_br);
    endtask

    // Advance one clock: update model from current inputs, then check at the falling edge
    task automatic cycle();
        logic        acc, pop;
        logic [31:0] fd;
        logic [3:0]  nf, old_f;
        ent_t        e;
        acc = ex_valid && (q.size() < 2);
        pop = (q.size() > 0) && wb_ready;
        fd = ex_movt ? {ex_dout[15:0], 16'h0000} : ex_dout;
        nf = {fd[31], fd == 32'd0, ex_vout, ex_cout};
        old_f = m_f;
`ifdef FLAG_SHADOW_EN
        if (flag_restore) m_f = m_sh;
        else if (acc && ex_setf) m_f = nf;
        if (flag_save) m_sh = old_f;
`else
        if (acc && ex_setf) m_f = nf;
`endif
        m_br = acc && ex_dj && ex_djtaken;
        if (pop) void'(q.pop_front());
        e = '{d: fd, r: ex_rdest, w: ex_wen};
        if (flush) q.delete();
        else if (acc) q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic push_op(input logic [31:0] d, input logic [3:0] r, input logic w,
                           input logic rdy);
        set_idle();
        ex_valid = 1; ex_dout = d; ex_rdest = r; ex_wen = w; wb_ready = rdy;
        cycle();
    endtask

    task automatic drain();
        set_idle();
        wb_ready = 1;
        repeat (3) cycle();
    endtask

    initial begin
        set_idle();
        wb_ready = 0;
        rst = 1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 0;
        compare_all();
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_rdest", wb_rdest, 4'd0);
        chk("rst_flag_c", flag_c, 1'b0);

        // ADD-style result of zero with carry
        set_idle();
        ex_valid = 1; ex_dout = 0; ex_cout = 1; ex_setf = 1; ex_wen = 1; wb_ready = 1;
        cycle();
        chk("t1_c", flag_c, 1'b1);
        chk("t1_z", flag_z, 1'b1);
        chk("t1_s", flag_s, 1'b0);
        chk("t1_wb_data", wb_data, 32'd0);
        drain();

        // MOVT places low half in the upper half
        set_idle();
        ex_valid = 1; ex_dout = 32'h0000_ABCD; ex_movt = 1; ex_rdest = 3; ex_wen = 1;
        ex_setf = 1; wb_ready = 0;
        cycle();
        chk("t2_wb_data", wb_data, 32'hABCD_0000);
        chk("t2_wb_rdest", wb_rdest, 4'd3);
        chk("t2_z", flag_z, 1'b0);
        chk("t2_s", flag_s, 1'b1);
        drain();

        // Backpressure: third request held while full
        push_op(32'h111, 4'd1, 1, 0);
        push_op(32'h222, 4'd2, 1, 0);
        chk("t3_ready_full", ex_ready, 1'b0);
        push_op(32'h333, 4'd3, 1, 0);
        chk("t3_held_head", wb_data, 32'h111);
        drain();

        // Forwarding: youngest writer wins, a CMP does not displace it
        push_op(32'd11, 4'd5, 1, 0);
        push_op(32'd22, 4'd5, 1, 0);
        chk("t4_fwd_data", fwd_data, 32'd22);
        chk("t4_fwd_rdest", fwd_rdest, 4'd5);
        push_op(32'd99, 4'd5, 0, 1);
        chk("t4_cmp_fwd", fwd_data, 32'd22);
        drain();

        // Decrement-jump pulse, then flush colliding with an accept
        set_idle();
        ex_valid = 1; ex_dj = 1; ex_djtaken = 1; ex_dout = 32'h5; wb_ready = 1;
        cycle();
        chk("t5_br_hi", br_taken, 1'b1);
        set_idle();
        cycle();
        chk("t5_br_lo", br_taken, 1'b0);
        set_idle();
        ex_valid = 1; flush = 1; ex_setf = 1; ex_cout = 1; ex_dout = 0; ex_wen = 1;
        wb_ready = 0;
        cycle();
        chk("t5_flush_empty", wb_valid, 1'b0);
        chk("t5_flush_c", flag_c, 1'b1);

        // Asynchronous reset while full
        push_op(32'hAAAA, 4'd7, 1, 0);
        push_op(32'hBBBB, 4'd8, 1, 0);
        set_idle();
        #2 rst = 1;
        #1;
        chk("t6_wb_valid", wb_valid, 1'b0);
        chk("t6_fwd_hit", fwd_hit_valid, 1'b0);
        chk("t6_flags", {flag_s, flag_z, flag_v, flag_c}, 4'd0);
        model_reset();
        @(negedge clk);
        rst = 0;
        compare_all();

`ifdef FLAG_SHADOW_EN
        set_idle();
        ex_valid = 1; ex_setf = 1; ex_cout = 1; ex_dout = 1; wb_ready = 1;
        cycle();
        set_idle();
        flag_save = 1;
        cycle();
        set_idle();
        ex_valid = 1; ex_setf = 1; ex_cout = 0; ex_dout = 1;
        cycle();
        chk("sh_cleared", flag_c, 1'b0);
        set_idle();
        flag_restore = 1;
        cycle();
        chk("sh_restored", flag_c, 1'b1);
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            set_idle();
            ex_valid = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 3))
                0:       ex_dout = 32'd0;
                1:       ex_dout = 32'h0001_0000;
                default: ex_dout = $urandom;
            endcase
            ex_cout    = $urandom_range(0, 1);
            ex_vout    = $urandom_range(0, 1);
            ex_dj      = ($urandom_range(0, 4) == 0);
            ex_djtaken = $urandom_range(0, 1);
            ex_rdest   = 4'($urandom_range(0, 15));
            ex_wen     = ($urandom_range(0, 3) != 0);
            ex_setf    = $urandom_range(0, 1);
            ex_movt    = ($urandom_range(0, 3) == 0);
            flush      = ($urandom_range(0, 19) == 0);
            wb_ready   = ($urandom_range(0, 9) < 6);
`ifdef FLAG_SHADOW_EN
            flag_save    = ($urandom_range(0, 9) == 0);
            flag_restore = ($urandom_range(0, 9) == 0);
`endif
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
